// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
// Holds the default word width, the FSM state encoding and the parity-mode values.
package fifo_pkg;

   localparam int DATA_W_DEF = 16;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: bit_tick marks the last cycle of each serial bit.
// restart reloads the count so the next bit starts a full period from now.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic restart,
   output logic bit_tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (restart || (count == '0)) begin
         count <= RELOAD;
      end else begin
         count <= count - 1'b1;
      end
   end

   assign bit_tick = (count == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a show-ahead FIFO and sends each as an async serial frame:
// start bit, DATA_W data bits LSB-first, optional parity bit, STOP_BITS stop bits.
module fifo_uart_tx
   import fifo_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              enable,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_read,
   output logic              tx,
   output logic              busy,
   output logic              word_done,
   output state_t            state
);

   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_W - 1);
   localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
   localparam logic          ODD_BIT   = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

   state_t            state_next;
   logic [DATA_W-1:0] shreg, shreg_next;
   logic [IW-1:0]     idx, idx_next;
   logic              par_bit, par_next;
   logic              tx_next;
   logic              restart;
   logic              bit_tick;
   logic              pop_ok;
   logic              sync_rst;

   assign sync_rst = reset | clear;
   assign pop_ok   = enable & ~fifo_empty;

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clock   (clock),
      .reset   (sync_rst),
      .restart (restart),
      .bit_tick(bit_tick)
   );

   always_comb begin
      state_next = state;
      shreg_next = shreg;
      idx_next   = idx;
      par_next   = par_bit;
      restart    = 1'b0;
      word_done  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pop_ok) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            shreg_next = fifo_data;
            par_next   = (^fifo_data) ^ ODD_BIT;
            restart    = 1'b1;
            state_next = ST_START;
         end
         ST_START: begin
            if (bit_tick) state_next = ST_DATA;
         end
         ST_DATA: begin
            if (bit_tick) begin
               if (idx == LAST_BIT) begin
                  idx_next   = '0;
                  state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  idx_next   = idx + 1'b1;
                  shreg_next = shreg >> 1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_tick) state_next = ST_STOP;
         end
         ST_STOP: begin
            // idx is reused to count stop bits
            if (bit_tick) begin
               if (idx == LAST_STOP) begin
                  idx_next   = '0;
                  word_done  = 1'b1;
                  state_next = pop_ok ? ST_LOAD : ST_IDLE;
               end else begin
                  idx_next = idx + 1'b1;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // tx is registered, so it is derived from where the FSM is going next
   always_comb begin
      tx_next = 1'b1;
      case (state_next)
         ST_START:  tx_next = 1'b0;
         ST_DATA:   tx_next = shreg_next[0];
         ST_PARITY: tx_next = par_bit;
         default:   tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clock) begin
      if (sync_rst) begin
         state     <= ST_IDLE;
         shreg     <= '0;
         idx       <= '0;
         par_bit   <= 1'b0;
         tx        <= 1'b1;
         fifo_read <= 1'b0;
      end else begin
         state     <= state_next;
         shreg     <= shreg_next;
         idx       <= idx_next;
         par_bit   <= par_next;
         tx        <= tx_next;
         fifo_read <= (state_next == ST_LOAD);
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a no-parity instance fed by a small FIFO model,
// plus even- and odd-parity instances for the parity frame.
module tb_fifo_uart_tx;
   import fifo_pkg::*;

   logic        clock;
   logic        reset;
   logic        clear;
   logic        enable;
   logic        fifo_empty;
   logic [15:0] fifo_data;
   logic        fifo_read, tx, busy, word_done;
   state_t      state_m;

   logic        p_empty;
   logic [15:0] p_data;
   logic        rd_e, tx_e, busy_e, wd_e;
   logic        rd_o, tx_o, busy_o, wd_o;
   state_t      st_e, st_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- DUTs ----------------
   fifo_uart_tx #(.DATA_W(16), .CLKS_PER_BIT(4)) dut (
      .clock(clock), .reset(reset), .clear(clear), .enable(enable),
      .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read(fifo_read),
      .tx(tx), .busy(busy), .word_done(word_done), .state(state_m)
   );

   fifo_uart_tx #(.DATA_W(16), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_even (
      .clock(clock), .reset(reset), .clear(clear), .enable(enable),
      .fifo_empty(p_empty), .fifo_data(p_data), .fifo_read(rd_e),
      .tx(tx_e), .busy(busy_e), .word_done(wd_e), .state(st_e)
   );

   fifo_uart_tx #(.DATA_W(16), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
      .clock(clock), .reset(reset), .clear(clear), .enable(enable),
      .fifo_empty(p_empty), .fifo_data(p_data), .fifo_read(rd_o),
      .tx(tx_o), .busy(busy_o), .word_done(wd_o), .state(st_o)
   );

   // ---------------- FIFO model (show-ahead) ----------------
   logic [15:0] mem [16];
   int wr = 0;
   int rd = 0;
   int underflow = 0;

   always @(posedge clock) begin
      if (fifo_read) begin
         if (rd == wr) underflow <= underflow + 1;
         else          rd <= rd + 1;
      end
   end

   assign fifo_empty = (wr == rd);
   assign fifo_data  = mem[rd[3:0]];

   task automatic push(input logic [15:0] w);
      mem[wr[3:0]] = w;
      wr = wr + 1;
   endtask

   // ---------------- event logs ----------------
   int rd_log[$];
   int wd_log[$];
   int pe_rd[$], pe_wd[$], po_rd[$], po_wd[$];

   always @(negedge clock) begin
      if (fifo_read) rd_log.push_back(cyc);
      if (word_done) wd_log.push_back(cyc);
      if (rd_e)      pe_rd.push_back(cyc);
      if (wd_e)      pe_wd.push_back(cyc);
      if (rd_o)      po_rd.push_back(cyc);
      if (wd_o)      po_wd.push_back(cyc);
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic get_tx(input int idx);
      case (idx)
         1:       return tx_e;
         2:       return tx_o;
         default: return tx;
      endcase
   endfunction

   int fall_cyc [3];

   task automatic wait_fall(input int idx, output bit ok);
      int n = 0;
      while (get_tx(idx) !== 1'b0 && n < 300) begin
         @(negedge clock);
         n++;
      end
      ok = (n < 300);
      if (!ok) check("fall_timeout", 32'd0, 32'd1);
      fall_cyc[idx] = cyc;
   endtask

   // Samples mid-bit: first low negedge is 0.5 cycle into the start bit.
   task automatic recv(input int idx, input int nbits, input logic [16:0] exp, input string tag);
      bit ok;
      logic [16:0] b = '0;
      wait_fall(idx, ok);
      if (!ok) return;
      repeat (2) @(negedge clock);
      check({tag, "_start"}, 32'(get_tx(idx)), 32'd0);
      for (int i = 0; i < nbits; i++) begin
         repeat (4) @(negedge clock);
         b[i] = get_tx(idx);
      end
      check({tag, "_data"}, 32'(b), 32'(exp));
      repeat (4) @(negedge clock);
      check({tag, "_stop"}, 32'(get_tx(idx)), 32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n0, w0, f1, n;
      bit ok;
      reset   = 1'b1;
      clear   = 1'b0;
      enable  = 1'b0;
      p_empty = 1'b1;
      p_data  = 16'h0000;
      repeat (3) @(negedge clock);
      check("rst_outs", {28'd0, tx, busy, fifo_read, word_done}, 32'b1000);
      check("rst_state", 32'(state_m), 32'(ST_IDLE));
      reset  = 1'b0;
      enable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         check("idle_empty", {28'd0, tx, busy, fifo_read, word_done}, 32'b1000);
      end

      // single word
      n0 = rd_log.size();
      w0 = wd_log.size();
      push(16'hA5C3);
      recv(0, 16, {1'b0, 16'hA5C3}, "single");
      repeat (10) @(negedge clock);
      check("single_pops", 32'(rd_log.size() - n0), 32'd1);
      check("single_done", 32'(wd_log.size() - w0), 32'd1);
      if (rd_log.size() > 0 && wd_log.size() > 0)
         check("single_latency", 32'(wd_log[$] - rd_log[$]), 32'd72);
      check("single_idle", {31'd0, busy}, 32'd0);

      // back-to-back
      n0 = rd_log.size();
      w0 = wd_log.size();
      push(16'h0001);
      push(16'h8000);
      recv(0, 16, {1'b0, 16'h0001}, "b2b_a");
      f1 = fall_cyc[0];
      recv(0, 16, {1'b0, 16'h8000}, "b2b_b");
      check("b2b_frame_gap", 32'(fall_cyc[0] - f1), 32'd73);
      repeat (10) @(negedge clock);
      check("b2b_pops", 32'(rd_log.size() - n0), 32'd2);
      check("b2b_done", 32'(wd_log.size() - w0), 32'd2);
      if (rd_log.size() >= n0 + 2)
         check("b2b_pop_gap", 32'(rd_log[n0+1] - rd_log[n0]), 32'd73);

      // parity, even and odd instances side by side
      p_data  = 16'h0007;
      p_empty = 1'b0;
      n = 0;
      while (!rd_e && n < 50) begin
         @(negedge clock);
         n++;
      end
      check("par_pop_seen", {31'd0, rd_e}, 32'd1);
      p_empty = 1'b1;
      fork
         recv(1, 17, {1'b1, 16'h0007}, "par_even");
         recv(2, 17, {1'b0, 16'h0007}, "par_odd");
      join
      repeat (10) @(negedge clock);
      check("par_even_pops", 32'(pe_rd.size()), 32'd1);
      check("par_odd_pops", 32'(po_rd.size()), 32'd1);
      if (pe_rd.size() > 0 && pe_wd.size() > 0)
         check("par_even_len", 32'(pe_wd[0] - pe_rd[0]), 32'd76);
      if (po_rd.size() > 0 && po_wd.size() > 0)
         check("par_odd_len", 32'(po_wd[0] - po_rd[0]), 32'd76);

      // abort with clear during data bit 5
      n0 = rd_log.size();
      push(16'h1234);
      wait_fall(0, ok);
      repeat (26) @(negedge clock);
      check("abort_bit5", {30'd0, busy, tx}, 32'b11);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      check("abort_outs", {28'd0, tx, busy, fifo_read, word_done}, 32'b1000);
      check("abort_state", 32'(state_m), 32'(ST_IDLE));
      repeat (20) @(negedge clock);
      check("abort_no_repop", 32'(rd_log.size() - n0), 32'd1);

      // clear coinciding with the pop condition
      enable = 1'b0;
      push(16'h5555);
      clear  = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("clear_blocks_pop", {30'd0, busy, fifo_read}, 32'd0);
      end
      check("clear_pop_count", 32'(rd_log.size() - n0), 32'd1);
      clear = 1'b0;
      recv(0, 16, {1'b0, 16'h5555}, "after_clear");
      repeat (10) @(negedge clock);
      check("after_clear_pops", 32'(rd_log.size() - n0), 32'd2);

      // enable gating
      enable = 1'b0;
      n0 = rd_log.size();
      push(16'h5A5A);
      repeat (100) @(negedge clock);
      check("gate_no_pop", 32'(rd_log.size() - n0), 32'd0);
      check("gate_idle", {30'd0, busy, tx}, 32'b01);
      w0 = wd_log.size();
      enable = 1'b1;
      fork
         recv(0, 16, {1'b0, 16'h5A5A}, "gate_frame");
         begin
            repeat (20) @(negedge clock);
            enable = 1'b0;
            push(16'hBEEF);
         end
      join
      repeat (100) @(negedge clock);
      check("gate_mid_pops", 32'(rd_log.size() - n0), 32'd1);
      check("gate_mid_done", 32'(wd_log.size() - w0), 32'd1);
      check("gate_mid_idle", {30'd0, busy, tx}, 32'b01);

      check("fifo_underflow", 32'(underflow), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
